trig_counter_snap: RTL

//  Up/down event counter for the FrontPanel controls design.
//  - Events come from TriggerIn pulses and from debounced board buttons.
//  - The counter value is presented as an atomic 32-bit snapshot, split into two 16-bit words for okWireOut endpoints.
//  - Also produces a status word (sticky flags, debounced buttons, snapshot sequence) for a third okWireOut.
//  - Sits between okTriggerIn/board pins (upstream) and okWireOut endpoints (downstream); replaces ad-hoc counter logic in the top level.

---
 rtl/trig_counter_snap.sv | 136 +++++++++++++
 1 files changed

// File: rtl/trig_counter_snap.sv
// trig_counter_snap
//   Up/down event counter with an atomic 32-bit snapshot and a status word,
//   fed by one-cycle trigger pulses and debounced active-low board buttons.
//
// Ports
//   clk1     in   1   system clock (trigger pulses are synchronous to it)
//   rst_n    in   1   asynchronous active-low reset
//   trig_in  in   4   one-cycle pulses {snapshot, countdown, countup, clear}
//   button   in   4   raw board buttons, active-low, asynchronous
//   count    out  32  live counter value
//   snap_lo  out  16  snapshot[15:0]
//   snap_hi  out  16  snapshot[31:16]
//   status   out  16  {snap_seq[7:0], btn_db[3:0], 1'b0, snap_valid, unf, ovf}
//   btn_db   out  4   debounced buttons, active-high (1 = pressed)
//
// Every output is a register or a concatenation of registers.

module trig_counter_snap #(
  parameter int WIDTH      = 32,     // fixed at 32: the snapshot splits into two 16-bit words
  parameter int DEB_CYCLES = 50000,  // stable cycles needed to accept a button change (>= 2)
  parameter bit WRAP       = 1'b1    // 1: wrap at max/zero, 0: saturate
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic [3:0]       trig_in,
  input  logic [3:0]       button,
  output logic [WIDTH-1:0] count,
  output logic [15:0]      snap_lo,
  output logic [15:0]      snap_hi,
  output logic [15:0]      status,
  output logic [3:0]       btn_db
);

  localparam int DCW = $clog2(DEB_CYCLES);
  localparam logic [DCW-1:0] DEB_LAST = DCW'(DEB_CYCLES - 1);

  logic [3:0]       sync1, sync2;
  logic [DCW-1:0]   deb_cnt [4];
  logic [3:0]       deb_hit;
  logic [1:0]       press;
  logic             up, dn;
  logic             ovf, unf, snap_valid;
  logic [7:0]       snap_seq;
  logic [WIDTH-1:0] snapshot;

  // Synchronizers idle at 1 so a button held through reset is not seen as
  // already accepted; it must be re-qualified after reset releases.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
    end
  end

  // The accepted raw level is ~btn_db; a hit means the synced level has
  // differed for DEB_CYCLES consecutive cycles.
  always_comb begin
    deb_hit = '0;
    for (int i = 0; i < 4; i++)
      deb_hit[i] = (sync2[i] == btn_db[i]) && (deb_cnt[i] == DEB_LAST);
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
      btn_db <= '0;
      press  <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] != btn_db[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_hit[i]) begin
          deb_cnt[i] <= '0;
          btn_db[i]  <= ~sync2[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DCW'(1);
        end
      end
      // Only an accepted press (raw level going low) produces an event.
      press <= deb_hit[1:0] & ~sync2[1:0];
    end
  end

  assign up = trig_in[1] | press[0];
  assign dn = trig_in[2] | press[1];

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (trig_in[0]) begin
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (up && dn) begin
      count <= count;
    end else if (up) begin
      if (count == '1) begin
        ovf <= 1'b1;
        if (WRAP) count <= '0;
      end else begin
        count <= count + WIDTH'(1);
      end
    end else if (dn) begin
      if (count == '0) begin
        unf <= 1'b1;
        if (WRAP) count <= '1;
      end else begin
        count <= count - WIDTH'(1);
      end
    end
  end

  // Snapshot captures the pre-update count, so a same-cycle clear or step
  // does not leak into it.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      snapshot   <= '0;
      snap_valid <= 1'b0;
      snap_seq   <= '0;
    end else if (trig_in[3]) begin
      snapshot   <= count;
      snap_valid <= 1'b1;
      snap_seq   <= snap_seq + 8'd1;
    end
  end

  assign snap_lo = snapshot[15:0];
  assign snap_hi = snapshot[WIDTH-1:16];
  assign status  = {snap_seq, btn_db, 1'b0, snap_valid, unf, ovf};

endmodule
